// File: rtl/instruction_fetch.sv
// instruction_fetch: tick-paced fetch stage between a synchronous instruction
// ROM and the execute stage, with PC wrap/skip handling and valid/ready output.
module instruction_fetch #(
  parameter int unsigned TICK_DIV    = 10000000,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned LAST_ADDR   = 14,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        instr,
  output logic [4:0]        instr_opcode,
  output logic [2:0]        instr_operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              skip,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              tick,
  output logic              overrun
);

  localparam int unsigned DIV_W  = $clog2(TICK_DIV);
  localparam int unsigned WAIT_W = $clog2(ROM_LATENCY + 1);
  localparam int unsigned PC_WW  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_VALID
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic               r_tick;
  logic [WAIT_W-1:0]  r_wait;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [ADDR_W-1:0]  r_pc;
  logic [7:0]         r_instr;
  logic               r_valid;
  logic               r_overrun;
  logic               w_start;
  logic               w_capture;
  logic               w_accept;
  logic [PC_WW-1:0]   w_pc_sum;
  logic [PC_WW-1:0]   w_pc_wrap;
  logic [ADDR_W-1:0]  w_pc_nxt;

  // Free-running step divider; tick is registered so it lines up with count TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_W'(TICK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
      r_tick <= (r_div == DIV_W'(TICK_DIV - 2));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tick && !halt) begin
          w_start     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (r_valid && instr_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next PC: step by 1 or 2 and fold back past LAST_ADDR in one extra bit
  always_comb begin
    w_pc_sum  = {1'b0, r_pc} + (skip ? PC_WW'(2) : PC_WW'(1));
    w_pc_wrap = (w_pc_sum > PC_WW'(LAST_ADDR)) ? w_pc_sum - PC_WW'(LAST_ADDR + 1) : w_pc_sum;
    w_pc_nxt  = w_pc_wrap[ADDR_W-1:0];
  end

  // Fetch datapath: ROM address, latency counter, instruction capture, PC, overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_wait     <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start) begin
        r_rom_addr <= r_pc;
      end
      if (r_state == S_ISSUE) begin
        r_wait <= WAIT_W'(ROM_LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_wait != '0)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
      if (w_capture) begin
        r_instr <= rom_data;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_pc    <= w_pc_nxt;
      end
      if (r_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign rom_addr      = r_rom_addr;
  assign instr         = r_instr;
  assign instr_opcode  = r_instr[7:3];
  assign instr_operand = r_instr[2:0];
  assign instr_valid   = r_valid;
  assign pc            = r_pc;
  assign tick          = r_tick;
  assign overrun       = r_overrun;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage placed between the 32-entry synchronous instruction ROM and the accumulator execute stage. The block contains its own step-rate tick divider and a program counter with wrap and skip handling. Each fetch issues an address to the ROM and waits out the ROM read latency. The 8-bit instruction is then presented to the execute stage over a valid/ready handshake, replacing the ad-hoc slow-clock fetch with a single-clock, flow-controlled stage.

## Interface
- TICK_DIV, 10000000: clk cycles per fetch tick (≥2)
- ADDR_W, 5: ROM address / PC width
- LAST_ADDR, 14: highest executed address; PC wraps after it (< 2^ADDR_W)
- ROM_LATENCY, 1: clk edges from ROM sampling rom_addr to valid rom_data (≥1)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  address to ROM addra (registered)
- rom_data  in  8  ROM douta
- instr  out  8  captured instruction (registered)
- instr_opcode  out  5  instr[7:3]
- instr_operand  out  3  instr[2:0]
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  execute stage accepts instr this cycle
- skip  in  1  sampled at handshake; skip the following instruction
- halt  in  1  suppress starting new fetches
- pc  out  ADDR_W  address of the instruction currently fetched/held
- tick  out  1  one-cycle fetch strobe
- overrun  out  1  sticky: a tick was dropped

## Operation
- Reset values: rom_addr=0, instr=0, instr_valid=0, pc=0, tick=0, overrun=0, divider=0, state=IDLE.
- Divider counts 0..TICK_DIV-1 and wraps; tick is high for the cycle in which the count equals TICK_DIV-1. The divider free-runs and is unaffected by halt or backpressure.
- FSM states:
  - IDLE: on tick && !halt, set rom_addr<=pc and go to ISSUE. On tick && halt, stay; not an overrun.
  - ISSUE: ROM samples rom_addr on this edge. Load the wait counter with ROM_LATENCY-1 and go to WAIT.
  - WAIT: decrement the wait counter. When it is 0, instr<=rom_data, instr_valid<=1, go to VALID.
  - VALID: hold instr stable. On instr_valid && instr_ready: instr_valid<=0, pc<=next_pc, go to IDLE.
- next_pc is computed in ADDR_W+1 bits as n = pc + (skip ? 2 : 1); if n > LAST_ADDR, then n - (LAST_ADDR+1). Examples: 14+1→0; 14+2→1; 13+2→0.
- skip is only sampled on the handshake edge and ignored otherwise.
- A tick in any state other than IDLE is dropped and sets overrun. overrun clears only on reset.
- halt has no effect once a fetch has left IDLE; the in-flight fetch completes.
- instr_opcode and instr_operand are pure slices of the registered instr.

## Timing
- Tick seen in IDLE at edge T: rom_addr updated after T. ROM samples at T+1. instr and instr_valid are updated after edge T+1+ROM_LATENCY (default: T+2).
- instr_ready held high: the handshake completes at the first edge where instr_valid=1, so valid lasts one cycle. pc advances after that edge and the FSM is back in IDLE one cycle later.
- First tick after reset is high in cycle TICK_DIV-1, sampled at edge TICK_DIV.
- A tick on the same edge as the handshake (FSM in VALID) is dropped and sets overrun. The FSM must be in IDLE to accept a tick.
- rst at any edge overrides all other inputs. The in-flight fetch is abandoned and all outputs return to reset values after that edge. A late rom_data is ignored.
- Minimum tick period without overrun: TICK_DIV ≥ ROM_LATENCY+3 when instr_ready is tied high.

## Test plan
- ROM[a]=0x10+a, TICK_DIV=4, instr_ready=1, skip=0 → instr sequence 0x10..0x1E, then 0x10 again; pc 14→0; overrun stays 0.
- Same setup, instr_ready low for 12 cycles while instr_valid=1 → instr and pc stable, overrun=1 after the next tick, fetch resumes at the first tick after release.
- skip=1 on the handshake at pc=3 → next rom_addr=5, instr=0x15. skip=1 at pc=14 → next rom_addr=1, instr=0x11.
- halt=1 across 3 ticks → rom_addr and instr_valid unchanged, overrun=0. Release → fetch starts on the following tick.
- rst pulsed while in WAIT (pc=6) → after that edge: instr_valid=0, instr=0, pc=0, rom_addr=0. The next fetch begins at edge TICK_DIV after reset release.
- ROM_LATENCY=2, TICK_DIV=8 → instr_valid rises exactly 3 edges after the accepting tick edge, with correct data.
